ifetch_line_responder: RTL
==========================

IFETCH_LINE_RESPONDER -- requirements
Module: ifetch_line_responder

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL expose these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  async active-high reset.
- pc_index_valid  in  1  fetch request from IFU.
- pc_index  in  19  PC[21:3], a 64-bit word index.
- pc_index_ready  out  1  request accepted when high together with pc_index_valid.
- pc_operation_done  out  1  one-cycle pulse; pc_read_inst valid this cycle.
- pc_read_inst  out  512  fetched line, word k at bits [64k+63:64k].
- flush  in  1  abandon the in-flight fetch (redirect).
- mem_req_valid  out  1  word read request to backing memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  19  word index requested.
- mem_rdata_valid  in  1  read beat returning, in request order.
- mem_rdata  in  64  read beat data.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-004 In IDLE, pc_index_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 On pc_index_valid && pc_index_ready, the block SHALL latch base = {pc_index[18:3],3'b000}, clear both counters and the flush flag, and enter ISSUE.
REQ-006 In ISSUE, mem_req_valid SHALL be 1 and mem_addr SHALL be base + issue_cnt; issue_cnt (4-bit) SHALL increment on mem_req_valid && mem_req_ready.
REQ-007 Requests SHALL be pipelined: issuing is not gated on returned beats; at most 8 requests SHALL be issued per line.
REQ-008 After the 8th request is accepted, the FSM SHALL enter DRAIN and mem_req_valid SHALL be 0.
REQ-009 Each mem_rdata_valid SHALL write mem_rdata into line slot recv_cnt[2:0], and recv_cnt (4-bit) SHALL increment, in both ISSUE and DRAIN.
REQ-010 When recv_cnt reaches 8 without flush, the FSM SHALL enter DONE; in DONE, pc_operation_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-011 Minimum latency with zero-wait memory (ready=1, data the next cycle) SHALL be 10 cycles from acceptance to done.
REQ-012 pc_read_inst SHALL hold its last completed line until the next DONE; partial fills SHALL NOT be visible at the output.
REQ-013 A flush in ISSUE SHALL stop further requests immediately (same cycle, mem_req_valid=0), set the flush flag and enter DRAIN.
REQ-014 DRAIN SHALL absorb every outstanding beat (recv_cnt == issue_cnt) and then return to IDLE with no done pulse if the flush flag is set.
REQ-015 A flush in IDLE or DONE SHALL have no effect; a done pulse already in DONE SHALL still be emitted.
REQ-016 A flush and a 8th-beat arrival in the same DRAIN cycle SHALL suppress done.
REQ-017 mem_rdata_valid in IDLE SHALL be ignored.
REQ-018 Address arithmetic SHALL be 19-bit modulo and wrap silently at 2^19.

Reset
REQ-019 On reset, the FSM SHALL go to IDLE; pc_index_ready=1, pc_operation_done=0, mem_req_valid=0, mem_addr=0, pc_read_inst=0, counters=0 and the flush flag=0.
REQ-020 Reset mid-fetch SHALL discard all state; late beats arriving after reset SHALL be ignored by REQ-017.

Structure
REQ-021 LINE_WORDS=8, the state enum and the 19-bit index width SHALL live in the shared defines package.
REQ-022 The block SHALL be a single module with no sub-modules; an optional line-assembly register may be factored as ifetch_line_buf.

Verification
REQ-023 Zero-wait memory, pc_index=19'h00005, words = base+k -> mem_addr 0..7, done at cycle 10, pc_read_inst word k = k.
REQ-024 mem_req_ready toggling 1/0 and random 0-3 cycle data delay -> 8 requests, exactly one done, line correct.
REQ-025 flush after 3 requests are accepted with 2 beats returned -> no further requests, 1 more beat absorbed, no done, ready=1 afterwards.
REQ-026 pc_index=19'h7FFFF -> base 19'h7FFF8, addresses ..7FFFF, no wrap beyond; a separate base+k overflow check wraps at 2^19.
REQ-027 Reset asserted during DRAIN with beats still outstanding -> outputs at reset values, stray beats ignored, and the next fetch completes correctly.

Source files
------------

// File: rtl/ifetch_line_responder_pkg.sv
// ifetch_line_responder_pkg
// Shared definitions for the instruction-fetch line responder:
//   LINE_WORDS / IDX_W / WORD_W / LINE_W / CNT_W  - geometry of a fetched line
//   state_e                                       - responder FSM states
//   line_addr()                                   - 19-bit modulo word address
package ifetch_line_responder_pkg;

  localparam int LINE_WORDS = 8;
  localparam int IDX_W      = 19;
  localparam int WORD_W     = 64;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word index of slot k of a line; wraps silently at 2^19.
  function automatic logic [IDX_W-1:0] line_addr(input logic [IDX_W-1:0] base,
                                                 input logic [CNT_W-1:0] k);
    return base + {{(IDX_W-CNT_W){1'b0}}, k};
  endfunction

endpackage

// File: rtl/ifetch_line_responder.sv
// ifetch_line_responder
// Fetches an aligned 8-word instruction line from a pipelined word memory
// on behalf of the IFU and presents it as a single 512-bit result.
// Ports:
//   clock, reset                  - sole clock (rising), async active-high reset
//   pc_index_valid/_ready, pc_index - fetch request (64-bit word index)
//   pc_operation_done, pc_read_inst - one-cycle done pulse with the line
//   flush                          - abandon the in-flight fetch
//   mem_req_valid/_ready, mem_addr - word read requests to memory
//   mem_rdata_valid, mem_rdata     - in-order read beats from memory
module ifetch_line_responder
  import ifetch_line_responder_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_index_valid,
  input  logic [IDX_W-1:0]  pc_index,
  output logic              pc_index_ready,
  output logic              pc_operation_done,
  output logic [LINE_W-1:0] pc_read_inst,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic              mem_rdata_valid,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic [CNT_W-1:0]   recv_nxt;
  logic               flush_q, flush_d;
  logic               flush_seen;
  logic               beat_en;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  inst_q, inst_d;

  // Next-state, line assembly and handshake outputs.
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    issue_cnt_d       = issue_cnt_q;
    recv_cnt_d        = recv_cnt_q;
    flush_d           = flush_q;
    line_d            = line_q;
    inst_d            = inst_q;
    pc_index_ready    = 1'b0;
    pc_operation_done = 1'b0;
    mem_req_valid     = 1'b0;
    mem_addr          = {IDX_W{1'b0}};

    // Beats are only meaningful while a line is being gathered; stray
    // beats in IDLE/DONE (e.g. left over from a reset) are dropped.
    beat_en    = mem_rdata_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    recv_nxt   = recv_cnt_q + {{(CNT_W-1){1'b0}}, beat_en};
    flush_seen = flush_q | flush;

    if (beat_en) begin
      line_d[{recv_cnt_q[2:0], 6'd0} +: WORD_W] = mem_rdata;
      recv_cnt_d = recv_nxt;
    end else begin
      recv_cnt_d = recv_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        pc_index_ready = 1'b1;
        if (pc_index_valid) begin
          base_d      = {pc_index[IDX_W-1:3], 3'b000};
          issue_cnt_d = {CNT_W{1'b0}};
          recv_cnt_d  = {CNT_W{1'b0}};
          flush_d     = 1'b0;
          state_d     = ST_ISSUE;
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // A redirect kills the request in the same cycle it is seen.
        if (flush) begin
          flush_d = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          mem_req_valid = 1'b1;
          mem_addr      = line_addr(base_q, issue_cnt_q);
          if (mem_req_ready) begin
            issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (issue_cnt_q == CNT_W'(LINE_WORDS - 1)) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_DRAIN: begin
        flush_d = flush_seen;
        // A flush arriving with the last beat still wins over done.
        if (flush_seen) begin
          if (recv_nxt == issue_cnt_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (recv_nxt == CNT_W'(LINE_WORDS)) begin
          inst_d  = line_d;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DONE: begin
        pc_operation_done = 1'b1;
        state_d           = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, assembly buffer and published line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= {IDX_W{1'b0}};
      issue_cnt_q <= {CNT_W{1'b0}};
      recv_cnt_q  <= {CNT_W{1'b0}};
      flush_q     <= 1'b0;
      line_q      <= {LINE_W{1'b0}};
      inst_q      <= {LINE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      flush_q     <= flush_d;
      line_q      <= line_d;
      inst_q      <= inst_d;
    end
  end

  assign pc_read_inst = inst_q;

endmodule
